// File: rtl/nco_pkg.sv
// Shared types and elaboration-time helpers for the quadrature NCO.
// The quarter-wave table is computed by constant functions, so it never needs an init file.
package nco_pkg;

  localparam int  MAX_ADDR_W = 12;
  localparam int  MAX_Q      = 1 << (MAX_ADDR_W - 2);
  localparam int  IDX_W      = MAX_ADDR_W - 1;
  localparam int  TAB_W      = 16;
  localparam real PI         = 3.14159265358979323846;

  typedef logic [MAX_Q:0][TAB_W-1:0] qtab_t;

  typedef struct packed {
    logic             vld;
    logic             wrap;
    logic             sin_neg;
    logic             cos_neg;
    logic [IDX_W-1:0] sin_idx;
    logic [IDX_W-1:0] cos_idx;
  } s1_t;

  function automatic int quarter_len(input int addr_w);
    return 1 << (addr_w - 2);
  endfunction

  function automatic int peak_amp(input int amp_w);
    return (1 << (amp_w - 1)) - 1;
  endfunction

  // Odd Taylor series; argument never exceeds pi/2, so the error is far below one LSB.
  function automatic real sin_series(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int k = 1; k < 12; k++) begin
      term = -term * x * x / $itor((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic qtab_t quarter_sine(input int addr_w, input int amp_w);
    qtab_t tab;
    real   v;
    tab = '0;
    for (int i = 0; i <= quarter_len(addr_w); i++) begin
      v = $itor(peak_amp(amp_w)) *
          sin_series(PI / 2.0 * $itor(i) / $itor(quarter_len(addr_w)));
      tab[i] = TAB_W'($rtoi(v + 0.5));
    end
    return tab;
  endfunction

endpackage

// File: rtl/nco_qsine_rom.sv
// Quarter-wave sine magnitude ROM, Q+1 words, two registered read ports
// shared by the sine and cosine paths.
module nco_qsine_rom
  import nco_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int AMP_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] addr_a,
  input  logic [IDX_W-1:0] addr_b,
  output logic [AMP_W-2:0] data_a,
  output logic [AMP_W-2:0] data_b
);

  localparam qtab_t TAB = quarter_sine(ADDR_W, AMP_W);

  logic [AMP_W-2:0] data_a_d, data_a_q;
  logic [AMP_W-2:0] data_b_d, data_b_q;

  always_comb begin
    data_a_d = TAB[addr_a][AMP_W-2:0];
    data_b_d = TAB[addr_b][AMP_W-2:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end

  assign data_a = data_a_q;
  assign data_b = data_b_q;

endmodule

// File: rtl/nco_quadrature.sv
// Quadrature NCO: phase accumulator, quadrant fold, shared quarter-wave ROM,
// sign restore. Three-stage free-running pipeline, one sample per en.
module nco_quadrature
  import nco_pkg::*;
#(
  parameter int PHASE_W = 24,
  parameter int ADDR_W  = 8,
  parameter int AMP_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [PHASE_W-1:0]      freq_word,
  input  logic                    load_freq,
  input  logic [ADDR_W-1:0]       phase_offset,
  input  logic                    sync_clr,
  output logic                    out_valid,
  output logic signed [AMP_W-1:0] cos_out,
  output logic signed [AMP_W-1:0] sin_out,
  output logic                    wrap
);

  localparam int Q = quarter_len(ADDR_W);

  // Returns {negate, table index}; odd quadrants mirror to Q-i, which reaches word Q at i=0.
  function automatic logic [IDX_W:0] fold(input logic [ADDR_W-1:0] ph);
    logic [ADDR_W-2:0] i_lin;
    logic [ADDR_W-2:0] idx;
    i_lin = {1'b0, ph[ADDR_W-3:0]};
    idx   = ph[ADDR_W-2] ? (ADDR_W-1)'(Q) - i_lin : i_lin;
    return {ph[ADDR_W-1], IDX_W'(idx)};
  endfunction

  function automatic logic signed [AMP_W-1:0] apply_sign(input logic [AMP_W-2:0] mag,
                                                         input logic neg);
    logic signed [AMP_W-1:0] m;
    m = signed'({1'b0, mag});
    return neg ? -m : m;
  endfunction

  logic [PHASE_W-1:0]      acc_d, acc_q;
  logic [PHASE_W-1:0]      freq_d, freq_q;
  logic [PHASE_W:0]        step_sum;
  logic [ADDR_W-1:0]       p_sin, p_cos;
  s1_t                     s1_p1_d, s1_p1_q;
  logic [AMP_W-2:0]        sin_mag_p2, cos_mag_p2;
  logic                    vld_p2_d, vld_p2_q;
  logic                    wrap_p2_d, wrap_p2_q;
  logic                    sin_neg_p2_d, sin_neg_p2_q;
  logic                    cos_neg_p2_d, cos_neg_p2_q;
  logic                    out_valid_d, out_valid_q;
  logic                    wrap_d, wrap_q;
  logic signed [AMP_W-1:0] cos_d, cos_q;
  logic signed [AMP_W-1:0] sin_d, sin_q;

  always_comb begin
    step_sum = {1'b0, acc_q} + {1'b0, freq_q};
    freq_d   = load_freq ? freq_word : freq_q;
    acc_d    = acc_q;
    if (sync_clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = step_sum[PHASE_W-1:0];
    end
  end

  // Stage 1: lookup phase from the pre-update accumulator, folded indices and signs
  always_comb begin
    p_sin        = acc_q[PHASE_W-1 -: ADDR_W] + phase_offset;
    p_cos        = p_sin + ADDR_W'(Q);
    s1_p1_d      = '0;
    s1_p1_d.vld  = en;
    s1_p1_d.wrap = en & ~sync_clr & step_sum[PHASE_W];
    {s1_p1_d.sin_neg, s1_p1_d.sin_idx} = fold(p_sin);
    {s1_p1_d.cos_neg, s1_p1_d.cos_idx} = fold(p_cos);
  end

  // Stage 2: table reads (registered inside the ROM) with control alongside
  nco_qsine_rom #(
    .ADDR_W (ADDR_W),
    .AMP_W  (AMP_W)
  ) u_rom (
    .clk    (clk),
    .rst    (rst),
    .addr_a (s1_p1_q.sin_idx),
    .addr_b (s1_p1_q.cos_idx),
    .data_a (sin_mag_p2),
    .data_b (cos_mag_p2)
  );

  always_comb begin
    vld_p2_d     = s1_p1_q.vld;
    wrap_p2_d    = s1_p1_q.wrap;
    sin_neg_p2_d = s1_p1_q.sin_neg;
    cos_neg_p2_d = s1_p1_q.cos_neg;
  end

  // Stage 3: sign restore; outputs hold when no sample arrives
  always_comb begin
    out_valid_d = vld_p2_q;
    cos_d       = cos_q;
    sin_d       = sin_q;
    wrap_d      = wrap_q;
    if (vld_p2_q) begin
      cos_d  = apply_sign(cos_mag_p2, cos_neg_p2_q);
      sin_d  = apply_sign(sin_mag_p2, sin_neg_p2_q);
      wrap_d = wrap_p2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      freq_q       <= '0;
      s1_p1_q      <= '0;
      vld_p2_q     <= 1'b0;
      wrap_p2_q    <= 1'b0;
      sin_neg_p2_q <= 1'b0;
      cos_neg_p2_q <= 1'b0;
      out_valid_q  <= 1'b0;
      wrap_q       <= 1'b0;
      cos_q        <= '0;
      sin_q        <= '0;
    end else begin
      acc_q        <= acc_d;
      freq_q       <= freq_d;
      s1_p1_q      <= s1_p1_d;
      vld_p2_q     <= vld_p2_d;
      wrap_p2_q    <= wrap_p2_d;
      sin_neg_p2_q <= sin_neg_p2_d;
      cos_neg_p2_q <= cos_neg_p2_d;
      out_valid_q  <= out_valid_d;
      wrap_q       <= wrap_d;
      cos_q        <= cos_d;
      sin_q        <= sin_d;
    end
  end

  assign out_valid = out_valid_q;
  assign cos_out   = cos_q;
  assign sin_out   = sin_q;
  assign wrap      = wrap_q;

endmodule
